// File: rtl/l1ram_arbiter_if.sv
// l1ram_arbiter_if
// Bundles the two requester command/response ports and the L1 RAM
// (32 x 96 simple dual-port, registered read) drive signals.
//
// Signals
//   a_valid/a_we/a_addr/a_wdata   requester A command
//   a_ready                       requester A command accepted this cycle
//   a_rvalid/a_rdata              requester A read response
//   b_*                           same set for requester B
//   ram_data/ram_wraddress/ram_wren   RAM write port
//   ram_rdaddress                 RAM read address
//   ram_q                         RAM registered read data
//
// Modports
//   slave   : the arbiter
//   master  : the environment (both requesters plus the RAM)
interface l1ram_arbiter_if #(
  parameter int DW = 96,
  parameter int AW = 5
);
  logic          a_valid;
  logic          a_ready;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_rvalid;
  logic [DW-1:0] a_rdata;

  logic          b_valid;
  logic          b_ready;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_rvalid;
  logic [DW-1:0] b_rdata;

  logic [DW-1:0] ram_data;
  logic [AW-1:0] ram_wraddress;
  logic          ram_wren;
  logic [AW-1:0] ram_rdaddress;
  logic [DW-1:0] ram_q;

  modport slave (
    input  a_valid, a_we, a_addr, a_wdata,
    output a_ready, a_rvalid, a_rdata,
    input  b_valid, b_we, b_addr, b_wdata,
    output b_ready, b_rvalid, b_rdata,
    output ram_data, ram_wraddress, ram_wren, ram_rdaddress,
    input  ram_q
  );

  modport master (
    output a_valid, a_we, a_addr, a_wdata,
    input  a_ready, a_rvalid, a_rdata,
    output b_valid, b_we, b_addr, b_wdata,
    input  b_ready, b_rvalid, b_rdata,
    input  ram_data, ram_wraddress, ram_wren, ram_rdaddress,
    output ram_q
  );
endinterface

// File: rtl/l1ram_arbiter.sv
// l1ram_arbiter
// Two-requester arbiter in front of a simple dual-port L1 RAM. The RAM
// write port and read port each have their own round-robin arbiter, so
// a write from one requester and a read from the other can both be
// granted in the same cycle. Read data comes back on the owning
// requester's response port one cycle after the grant.
//
// Ports
//   clock   sole clock, rising edge
//   reset   asynchronous, active-high
//   bus     l1ram_arbiter_if.slave (requester A/B ports, RAM drive)
//
// Optional build macro
//   L1RAM_ARB_BYPASS_EN : a read and write granted in the same cycle to
//   the same address return the newly written data instead of ram_q.
module l1ram_arbiter #(
  parameter int DW = 96,
  parameter int AW = 5
) (
  input  logic             clock,
  input  logic             reset,
  l1ram_arbiter_if.slave   bus
);

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  // Arbiter history: the requester that won the last two-way conflict.
  req_id_e wr_last_q, wr_last_d;
  req_id_e rd_last_q, rd_last_d;

  // Read response pipeline.
  logic    rsp_v_q, rsp_v_d;
  req_id_e rsp_id_q, rsp_id_d;

  // Read address holds its last value when there is no read grant.
  logic [AW-1:0] rd_addr_q, rd_addr_d;

  logic wr_cand_a, wr_cand_b, rd_cand_a, rd_cand_b;
  logic wr_gnt_a, wr_gnt_b, rd_gnt_a, rd_gnt_b;
  logic wr_gnt, rd_gnt;

  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rsp_data;

  // Candidates are masked by reset so ready stays low while it is held.
  always_comb begin
    wr_cand_a = bus.a_valid &  bus.a_we & ~reset;
    wr_cand_b = bus.b_valid &  bus.b_we & ~reset;
    rd_cand_a = bus.a_valid & ~bus.a_we & ~reset;
    rd_cand_b = bus.b_valid & ~bus.b_we & ~reset;
  end

  // Round-robin: with both candidates present, the one that did not win
  // the previous conflict gets the port.
  always_comb begin
    wr_gnt_a = wr_cand_a & (~wr_cand_b | (wr_last_q == REQ_B));
    wr_gnt_b = wr_cand_b & ~wr_gnt_a;
    rd_gnt_a = rd_cand_a & (~rd_cand_b | (rd_last_q == REQ_B));
    rd_gnt_b = rd_cand_b & ~rd_gnt_a;
    wr_gnt   = wr_gnt_a | wr_gnt_b;
    rd_gnt   = rd_gnt_a | rd_gnt_b;
  end

  // History only moves on a real conflict; a lone requester does not
  // change who wins the next contested cycle.
  always_comb begin
    wr_last_d = wr_last_q;
    rd_last_d = rd_last_q;
    if (wr_cand_a && wr_cand_b) begin
      wr_last_d = wr_gnt_b ? REQ_B : REQ_A;
    end
    if (rd_cand_a && rd_cand_b) begin
      rd_last_d = rd_gnt_b ? REQ_B : REQ_A;
    end
  end

  always_comb begin
    wr_addr = wr_gnt_b ? bus.b_addr  : bus.a_addr;
    wr_data = wr_gnt_b ? bus.b_wdata : bus.a_wdata;
  end

  always_comb begin
    rd_addr_d = rd_addr_q;
    if (rd_gnt_a) begin
      rd_addr_d = bus.a_addr;
    end else if (rd_gnt_b) begin
      rd_addr_d = bus.b_addr;
    end
  end

  always_comb begin
    rsp_v_d  = rd_gnt;
    rsp_id_d = rd_gnt_b ? REQ_B : REQ_A;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_last_q <= REQ_B;
      rd_last_q <= REQ_B;
      rsp_v_q   <= 1'b0;
      rsp_id_q  <= REQ_A;
      rd_addr_q <= '0;
    end else begin
      wr_last_q <= wr_last_d;
      rd_last_q <= rd_last_d;
      rsp_v_q   <= rsp_v_d;
      rsp_id_q  <= rsp_id_d;
      rd_addr_q <= rd_addr_d;
    end
  end

`ifdef L1RAM_ARB_BYPASS_EN
  // Same-cycle read/write to one address: the RAM would return the old
  // word, so keep the write data and substitute it on the response.
  logic          byp_hit_q, byp_hit_d;
  logic [DW-1:0] byp_data_q, byp_data_d;

  always_comb begin
    byp_hit_d  = rd_gnt & wr_gnt & (rd_addr_d == wr_addr);
    byp_data_d = byp_hit_d ? wr_data : byp_data_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      byp_hit_q  <= 1'b0;
      byp_data_q <= '0;
    end else begin
      byp_hit_q  <= byp_hit_d;
      byp_data_q <= byp_data_d;
    end
  end

  always_comb begin
    rsp_data = byp_hit_q ? byp_data_q : bus.ram_q;
  end
`else
  always_comb begin
    rsp_data = bus.ram_q;
  end
`endif

  always_comb begin
    bus.a_ready       = wr_gnt_a | rd_gnt_a;
    bus.b_ready       = wr_gnt_b | rd_gnt_b;
    bus.ram_wren      = wr_gnt;
    bus.ram_wraddress = wr_addr;
    bus.ram_data      = wr_data;
    bus.ram_rdaddress = rd_addr_d;
    bus.a_rvalid      = rsp_v_q & (rsp_id_q == REQ_A);
    bus.b_rvalid      = rsp_v_q & (rsp_id_q == REQ_B);
    bus.a_rdata       = rsp_data;
    bus.b_rdata       = rsp_data;
  end

endmodule
